// File: rtl/tlul_a_host_fifo.sv
// TL-UL A-channel host adapter: queues core requests in a DEPTH-entry FIFO and drives the A channel.
// Optional alignment checking is enabled by defining TLUL_A_ALIGN_CHK_EN.
module tlul_a_host_fifo #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32,
  parameter int unsigned SZW   = 2,
  parameter int unsigned SRC_W = 2,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned MW   = DW / 8,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_opcode_i,
  input  logic [AW-1:0]    req_address_i,
  input  logic [DW-1:0]    req_data_i,
  input  logic [SZW-1:0]   req_size_i,
  output logic             a_valid_o,
  input  logic             a_ready_i,
  output logic [2:0]       a_opcode_o,
  output logic [2:0]       a_param_o,
  output logic [SZW-1:0]   a_size_o,
  output logic [SRC_W-1:0] a_source_o,
  output logic [AW-1:0]    a_address_o,
  output logic [MW-1:0]    a_mask_o,
  output logic [DW-1:0]    a_data_o,
  output logic [CW-1:0]    fifo_count_o,
  output logic             err_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned LMW = $clog2(MW);

  typedef struct packed {
    logic [2:0]     opcode;
    logic [SZW-1:0] size;
    logic [AW-1:0]  address;
    logic [MW-1:0]  mask;
    logic [DW-1:0]  data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  entry_t          push_entry;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [MW-1:0]   push_mask;
  logic            push_hs, push, pop, misaligned;
  int unsigned     nbytes, offset;

  assign req_ready_o  = (count_q != CW'(DEPTH));
  assign a_valid_o    = (count_q != '0);
  assign fifo_count_o = count_q;
  assign push_hs      = req_valid_i & req_ready_o;
  assign push         = push_hs & ~misaligned;
  assign pop          = a_valid_o & a_ready_i;

  // Mask uses the low address bits aligned down to the transfer size.
  always_comb begin
    nbytes    = 32'd1 << req_size_i;
    offset    = (32'(req_address_i) % MW) & ~(nbytes - 32'd1);
    push_mask = '0;
    if (32'(req_size_i) >= LMW) begin
      push_mask = '1;
    end else begin
      for (int unsigned i = 0; i < MW; i++) begin
        push_mask[i] = (i >= offset) && (i < offset + nbytes);
      end
    end
  end

`ifdef TLUL_A_ALIGN_CHK_EN
  logic err_q, err_d;

  assign misaligned = (32'(req_size_i) > LMW) ||
                      ((32'(req_address_i) & (nbytes - 32'd1)) != 32'd0);

  // Misaligned requests complete the handshake but are dropped; flag them next cycle.
  always_comb begin
    err_d = push_hs & misaligned;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign misaligned = 1'b0;
  assign err_o      = 1'b0;
`endif

  always_comb begin
    push_entry.opcode  = req_opcode_i;
    push_entry.size    = req_size_i;
    push_entry.address = req_address_i;
    push_entry.mask    = push_mask;
    push_entry.data    = req_data_i;
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wptr_q] = push_entry;
    end
  end

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    src_d   = pop ? src_q + 1'b1 : src_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      src_q   <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      src_q   <= src_d;
    end
  end

  // Payload storage is intentionally not reset.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign a_opcode_o  = mem_q[rptr_q].opcode;
  assign a_param_o   = 3'd0;
  assign a_size_o    = mem_q[rptr_q].size;
  assign a_address_o = mem_q[rptr_q].address;
  assign a_mask_o    = mem_q[rptr_q].mask;
  assign a_data_o    = mem_q[rptr_q].data;
  assign a_source_o  = src_q;

endmodule
